mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_pkg.sv | 46 ++++
 rtl/mem_access_unit_load_align.sv | 29 ++
 rtl/mem_access_unit.sv | 131 +++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants and request decode helpers for the data-memory access unit.
// Imported by mem_access_unit and load_align.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int XLEN_BYTES = 4;

  // Unsigned widths exist only for loads; halves and words must be naturally aligned.
  function automatic logic req_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !off[0];
      F3_HU:   ok = !we && !off[0];
      F3_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [XLEN_BYTES-1:0] byte_enables(input logic [2:0] f3,
                                                         input logic [1:0] off);
    logic [XLEN_BYTES-1:0] be;
    be = '0;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = 4'b0011 << {off[1], 1'b0};
      F3_W:        be = 4'b1111;
      default:     be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load aligner: shifts the addressed lane down and extends it.
// Kept standalone so a cache refill path can reuse it.
module load_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] lane;

  // Word accesses are always aligned, so the shifted lane equals rdata for W.
  always_comb begin
    lane = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_BU:   result = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_H:    result = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_HU:   result = {{(XLEN-16){1'b0}}, lane[15:0]};
      F3_W:    result = lane;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit between execute and write-back: drives a
// ready-handshaked data bus and returns the aligned, extended load result.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_valid,
  input  logic                  mem_we,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       addr,
  input  logic [XLEN-1:0]       wdata,
  output logic                  stall,
  output logic                  done,
  output logic                  fault,
  output logic [XLEN-1:0]       data_from_MEM,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [XLEN-1:0]       bus_addr,
  output logic [XLEN_BYTES-1:0] bus_be,
  output logic [XLEN-1:0]       bus_wdata,
  input  logic                  bus_ready,
  input  logic [XLEN-1:0]       bus_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [CNT_W-1:0] wait_cnt;
  logic            fault_flag;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] load_result;

  logic in_idle;
  logic in_busy;
  logic in_done;
  logic legal;
  logic accept;
  logic reject;

  assign in_idle = (state == ST_IDLE);
  assign in_busy = (state == ST_BUSY);
  assign in_done = (state == ST_DONE);
  assign legal   = req_legal(mem_we, funct3, addr[1:0]);
  assign accept  = in_idle && mem_req_valid && legal;
  assign reject  = in_idle && mem_req_valid && !legal;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (bus_rdata),
    .offset (req_addr[1:0]),
    .funct3 (req_funct3),
    .result (load_result)
  );

  // Ready is checked before the timeout so a reply on the last count cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      fault_flag    <= 1'b0;
      data_from_MEM <= '0;
      req_we        <= 1'b0;
      req_funct3    <= F3_B;
      req_addr      <= '0;
      req_wdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_we     <= mem_we;
            req_funct3 <= funct3;
            req_addr   <= addr;
            req_wdata  <= wdata;
            wait_cnt   <= '0;
            fault_flag <= 1'b0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_ready) begin
            if (!req_we) begin
              data_from_MEM <= load_result;
            end
            fault_flag <= 1'b0;
            state      <= ST_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            fault_flag <= 1'b1;
            state      <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Illegal requests complete immediately in IDLE without touching the bus.
  always_comb begin
    stall = accept || in_busy;
    done  = reject || in_done;
    fault = reject || (in_done && fault_flag);
  end

  // Bus outputs are driven only in BUSY and come solely from the latched request.
  always_comb begin
    bus_req   = in_busy;
    bus_we    = in_busy && req_we;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    if (in_busy) begin
      bus_addr = {req_addr[XLEN-1:2], 2'b00};
      bus_be   = byte_enables(req_funct3, req_addr[1:0]);
      case (req_funct3)
        F3_B, F3_BU: bus_wdata = {(XLEN/8){req_wdata[7:0]}};
        F3_H, F3_HU: bus_wdata = {(XLEN/16){req_wdata[15:0]}};
        default:     bus_wdata = req_wdata;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a transaction-level model checked every
// cycle, plus directed accesses with hand-computed expectations.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall, done, fault, bus_req, bus_we;
  logic [31:0] data_from_MEM, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_req_valid(mem_req_valid), .mem_we(mem_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .fault(fault), .data_from_MEM(data_from_MEM), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Access size in bytes; 0 marks an undefined width code.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    if (sz == 0) return 1'b0;
    if (we && f3[2]) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    int mask = (1 << sz) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    int sz = size_of(f3);
    if (sz == 1) return {24'd0, w[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'd0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_extract(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
    int sz = size_of(f3);
    logic [31:0] v, msk;
    if (sz == 4) return rd;
    v = rd >> (8 * (a % 4));
    msk = (32'd1 << (8 * sz)) - 32'd1;
    v = v & msk;
    if (!f3[2] && v[8*sz-1]) v = v | ~msk;
    return v;
  endfunction

  // Model: an access is either outstanding (with a count of busy cycles spent) or finishing.
  bit          m_busy = 1'b0, m_fin = 1'b0, m_flt = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_data = '0;
  logic        m_we = 1'b0;
  logic [2:0]  m_f3 = '0;
  logic [31:0] m_addr = '0, m_wd = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_fin <= 1'b0; m_flt <= 1'b0; m_wait <= 0; m_data <= '0;
    end else if (m_fin) begin
      m_fin <= 1'b0;
    end else if (m_busy) begin
      if (bus_ready) begin
        m_busy <= 1'b0; m_fin <= 1'b1; m_flt <= 1'b0;
        if (!m_we) m_data <= m_extract(m_f3, m_addr, bus_rdata);
      end else if (m_wait + 1 >= TO) begin
        m_busy <= 1'b0; m_fin <= 1'b1; m_flt <= 1'b1;
      end else begin
        m_wait <= m_wait + 1;
      end
    end else if (mem_req_valid && m_legal(mem_we, funct3, addr)) begin
      m_busy <= 1'b1; m_wait <= 0;
      m_we <= mem_we; m_f3 <= funct3; m_addr <= addr; m_wd <= wdata;
    end
  end

  always @(negedge clk) begin : compare
    logic e_stall, e_done, e_fault;
    if (check_en) begin
      e_stall = m_busy;
      e_done  = m_fin;
      e_fault = m_fin && m_flt;
      if (!m_busy && !m_fin && mem_req_valid) begin
        if (m_legal(mem_we, funct3, addr)) e_stall = 1'b1;
        else begin e_done = 1'b1; e_fault = 1'b1; end
      end
      checkOutput("stall", {31'd0, stall}, {31'd0, e_stall});
      checkOutput("done", {31'd0, done}, {31'd0, e_done});
      checkOutput("fault", {31'd0, fault}, {31'd0, e_fault});
      checkOutput("bus_req", {31'd0, bus_req}, {31'd0, m_busy});
      checkOutput("bus_we", {31'd0, bus_we}, {31'd0, m_busy && m_we});
      checkOutput("bus_addr", bus_addr, m_busy ? (m_addr & ~32'd3) : 32'd0);
      checkOutput("bus_be", {28'd0, bus_be}, {28'd0, m_busy ? m_be(m_f3, m_addr) : 4'd0});
      checkOutput("bus_wdata", bus_wdata, m_busy ? m_wdata(m_f3, m_wd) : 32'd0);
      checkOutput("data_from_MEM", data_from_MEM, m_data);
    end
  end

  // Presents one request; ready_at is the BUSY cycle index (1-based) carrying bus_ready, 0 = never.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input int ready_at,
                               output int done_cyc, output int stall_cyc, output int req_cyc,
                               output logic [3:0] be_seen, output logic [31:0] wd_seen,
                               output logic flt_seen);
    done_cyc = -1; stall_cyc = 0; req_cyc = 0; be_seen = '0; wd_seen = '0; flt_seen = 1'b0;
    mem_req_valid = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      bus_ready = (ready_at > 0) && (c == ready_at);
      bus_rdata = bus_ready ? rd : 32'h5A5A_5A5A;
      @(negedge clk);
      if (stall) stall_cyc++;
      if (bus_req) begin req_cyc++; be_seen = bus_be; wd_seen = bus_wdata; end
      if (done) begin done_cyc = c; flt_seen = fault; break; end
    end
    @(posedge clk); #1;
    mem_req_valid = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
    if (done_cyc < 0) checkOutput("done_within_bound", 32'd0, 32'd1);
  endtask

  int dc, sc, rc;
  logic [3:0] be;
  logic [31:0] wd;
  logic fl;

  initial begin
    repeat (2) @(posedge clk);
    #1 check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_data", data_from_MEM, 32'd0);
    checkOutput("reset_bus_req", {31'd0, bus_req}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1'b0, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, dc, sc, rc, be, wd, fl);
    checkOutput("lw_be", {28'd0, be}, 32'hF);
    checkOutput("lw_done_cycle", dc, 2);
    checkOutput("lw_stall_cycles", sc, 2);
    checkOutput("lw_data", data_from_MEM, 32'hDEAD_BEEF);
    checkOutput("model_lw", m_data, 32'hDEAD_BEEF);

    applyStimulus(1'b0, F3_B, 32'h203, 32'h0, 32'h80FF_0000, 1, dc, sc, rc, be, wd, fl);
    checkOutput("lb_be", {28'd0, be}, 32'h8);
    checkOutput("lb_data", data_from_MEM, 32'hFFFF_FF80);
    applyStimulus(1'b0, F3_BU, 32'h203, 32'h0, 32'h80FF_0000, 1, dc, sc, rc, be, wd, fl);
    checkOutput("lbu_data", data_from_MEM, 32'h0000_0080);
    checkOutput("model_lbu", m_data, 32'h0000_0080);

    applyStimulus(1'b1, F3_H, 32'h302, 32'h1234_ABCD, 32'h0, 4, dc, sc, rc, be, wd, fl);
    checkOutput("sh_be", {28'd0, be}, 32'hC);
    checkOutput("sh_wdata", wd, 32'hABCD_ABCD);
    checkOutput("sh_req_cycles", rc, 4);
    checkOutput("sh_done_cycle", dc, 5);
    checkOutput("sh_data_kept", data_from_MEM, 32'h0000_0080);

    applyStimulus(1'b0, F3_W, 32'h101, 32'h0, 32'h0, 1, dc, sc, rc, be, wd, fl);
    checkOutput("mis_done_cycle", dc, 0);
    checkOutput("mis_fault", {31'd0, fl}, 32'd1);
    checkOutput("mis_stall_cycles", sc, 0);
    checkOutput("mis_req_cycles", rc, 0);

    applyStimulus(1'b1, F3_BU, 32'h10, 32'h0, 32'h0, 1, dc, sc, rc, be, wd, fl);
    checkOutput("sbu_illegal_fault", {31'd0, fl}, 32'd1);
    checkOutput("sbu_illegal_req", rc, 0);

    applyStimulus(1'b0, F3_W, 32'h500, 32'h0, 32'h0, 0, dc, sc, rc, be, wd, fl);
    checkOutput("to_done_cycle", dc, TO + 1);
    checkOutput("to_fault", {31'd0, fl}, 32'd1);
    checkOutput("to_data_kept", data_from_MEM, 32'h0000_0080);

    applyStimulus(1'b0, F3_W, 32'h504, 32'h0, 32'h1357_2468, TO, dc, sc, rc, be, wd, fl);
    checkOutput("lastcnt_fault", {31'd0, fl}, 32'd0);
    checkOutput("lastcnt_done_cycle", dc, TO + 1);
    checkOutput("lastcnt_data", data_from_MEM, 32'h1357_2468);

    applyStimulus(1'b0, F3_H, 32'h206, 32'h0, 32'h8001_0000, 2, dc, sc, rc, be, wd, fl);
    checkOutput("lh_data", data_from_MEM, 32'hFFFF_8001);
    applyStimulus(1'b0, F3_HU, 32'h206, 32'h0, 32'h8001_0000, 1, dc, sc, rc, be, wd, fl);
    checkOutput("lhu_data", data_from_MEM, 32'h0000_8001);

    applyStimulus(1'b1, F3_B, 32'h11, 32'h0000_00A5, 32'h0, 1, dc, sc, rc, be, wd, fl);
    checkOutput("sb_be", {28'd0, be}, 32'h2);
    checkOutput("sb_wdata", wd, 32'hA5A5_A5A5);
    applyStimulus(1'b1, F3_W, 32'h20, 32'hCAFE_F00D, 32'h0, 1, dc, sc, rc, be, wd, fl);
    checkOutput("sw_wdata", wd, 32'hCAFE_F00D);
    checkOutput("sw_data_kept", data_from_MEM, 32'h0000_8001);

    // Reset asserted in cycle 2 of a load that is still waiting for the bus.
    mem_req_valid = 1'b1; mem_we = 1'b0; funct3 = F3_W; addr = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; mem_req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_data", data_from_MEM, 32'd0);
    @(posedge clk); #1;

    applyStimulus(1'b0, F3_W, 32'h100, 32'h0, 32'h0123_4567, 1, dc, sc, rc, be, wd, fl);
    checkOutput("post_rst_done_cycle", dc, 2);
    checkOutput("post_rst_data", data_from_MEM, 32'h0123_4567);

    repeat (2) @(posedge clk);
    #1 check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
